interrupt_sequencer: RTL
========================

# interrupt_sequencer

Consumes the single-cycle delayed interrupt pulse produced by the interrupt delayer controller and runs the hardware interrupt entry sequence. It stalls and flushes the pipeline, pushes the return PC and the flags onto the stack through the memory stage, reads the ISR address from the interrupt vector, and loads it into the PC. It sits between the interrupt delayer and the fetch/memory stages.

## Interface
- DATA_W, 16: memory word width; PC is 2*DATA_W bits.
- FLAGS_W, 3: width of the flags register (Z, N, C); must be ≤ DATA_W.
- VEC_ADDR, 2: word address of the vector high word; the low word is at VEC_ADDR+1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- intr_in  in  1  delayed interrupt pulse from the interrupt delayer
- pc_in  in  2*DATA_W  return address, sampled when intr_in is accepted
- flags_in  in  FLAGS_W  flags, sampled together with pc_in
- mem_ack  in  1  memory stage has completed the current request this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1 on a read
- busy  out  1  sequence in progress (any state except IDLE)
- stall_fetch  out  1  hold PC and the IF/ID register
- flush  out  1  one-cycle flush of the IF/ID and ID/EX registers
- mem_push  out  1  stack-push request (memory stage writes mem_wdata at SP, then decrements SP)
- mem_rd  out  1  read request at mem_addr
- mem_addr  out  DATA_W  read address; 0 when mem_rd=0
- mem_wdata  out  DATA_W  push data; 0 when mem_push=0
- pc_load  out  1  one-cycle strobe: PC ← pc_load_val
- pc_load_val  out  2*DATA_W  ISR address

## Operation
- FSM states: IDLE, FLUSH, PUSH_HI, PUSH_LO, PUSH_FLG, RD_HI, RD_LO, LOAD.
- IDLE: if intr_in=1, capture pc_in and flags_in into internal registers and go to FLUSH.
- FLUSH: flush=1, then go to PUSH_HI unconditionally.
- PUSH_HI: mem_push=1, mem_wdata=saved_pc[2*DATA_W-1:DATA_W]. Advance on mem_ack.
- PUSH_LO: mem_push=1, mem_wdata=saved_pc[DATA_W-1:0]. Advance on mem_ack.
- PUSH_FLG: mem_push=1, mem_wdata=saved flags zero-extended to DATA_W. Advance on mem_ack.
- RD_HI: mem_rd=1, mem_addr=VEC_ADDR. On mem_ack, latch mem_rdata into vec_hi.
- RD_LO: mem_rd=1, mem_addr=VEC_ADDR+1 (modulo 2^DATA_W). On mem_ack, latch mem_rdata into vec_lo.
- LOAD: pc_load=1, pc_load_val={vec_hi,vec_lo}, then go to IDLE.
- Request signals are level: they stay asserted while mem_ack=0. A request completes only in a cycle where both the request and mem_ack are 1. mem_ack in IDLE, FLUSH and LOAD is ignored.
- stall_fetch=1 in every state except IDLE. busy equals stall_fetch.
- intr_in while busy: set a one-deep pending flag and capture nothing. On the LOAD→IDLE transition, if pending=1, the block treats IDLE as seeing intr_in. It then captures pc_in/flags_in in that IDLE cycle and clears pending. A second intr_in while pending is already set is dropped.
- intr_in together with LOAD: sets pending.
- Reset values: state=IDLE, pending=0, all outputs 0, saved registers 0. Reset in any state aborts the sequence immediately; no partial push is retried.

## Timing
- With mem_ack tied to 1: intr_in sampled at edge 0 → FLUSH in cycle 1, PUSH_HI in 2, PUSH_LO in 3, PUSH_FLG in 4, RD_HI in 5, RD_LO in 6, pc_load in 7, IDLE in 8.
- Each mem_ack=0 cycle adds one cycle to the current memory state.
- All outputs are Moore (decoded from the registered state and registers only). No combinational path from any input to any output.

## Configuration
- INTR_PUSH_FLAGS_EN defined: PUSH_FLG is part of the sequence (PUSH_LO→PUSH_FLG→RD_HI). pc_load occurs in cycle 7 with zero wait states.
- INTR_PUSH_FLAGS_EN undefined: PUSH_FLG does not exist, PUSH_LO goes directly to RD_HI, and flags_in is unused. pc_load occurs in cycle 6.

## Test plan
- Basic entry, ack tied 1, macro on: pc_in=0x0001_2345, flags_in=3'b101, vector words 0x0000/0x0100. Required: pushes 0x0001, 0x2345, 0x0005 on consecutive cycles; reads at addresses 2 then 3; pc_load_val=0x0000_0100 in cycle 7.
- Wait states: mem_ack low for 2 cycles during PUSH_LO and 1 cycle during RD_HI. Required: requests and data are held stable, pc_load arrives in cycle 10, and no duplicate push occurs.
- Nested request: intr_in pulsed in cycle 3 of a running sequence. Required: after LOAD, a single IDLE cycle captures the current pc_in, then a second full sequence runs. A third pulse in cycle 4 is dropped.
- Reset mid-sequence: rst=1 during RD_HI with pending=1. Required: next cycle all outputs are 0, busy=0, and no sequence starts when rst is released.
- Macro off: same stimulus as the basic entry test. Required: only 2 pushes occur, no flags push, and pc_load occurs in cycle 6.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: hardware interrupt entry (flush, push PC/flags, fetch vector, load PC).
// Optional flags push enabled by defining INTR_PUSH_FLAGS_EN.
module interrupt_sequencer #(
    parameter int DATA_W   = 16,
    parameter int FLAGS_W  = 3,
    parameter int VEC_ADDR = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  intr_in,
    input  logic [2*DATA_W-1:0]   pc_in,
    input  logic [FLAGS_W-1:0]    flags_in,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  stall_fetch,
    output logic                  flush,
    output logic                  mem_push,
    output logic                  mem_rd,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  pc_load,
    output logic [2*DATA_W-1:0]   pc_load_val
);

    localparam logic [DATA_W-1:0] VEC_HI_A = DATA_W'(VEC_ADDR);
    localparam logic [DATA_W-1:0] VEC_LO_A = VEC_HI_A + {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        PUSH_HI,
        PUSH_LO,
`ifdef INTR_PUSH_FLAGS_EN
        PUSH_FLG,
`endif
        RD_HI,
        RD_LO,
        LOAD
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                pending;
    logic                start;
    logic [2*DATA_W-1:0] saved_pc;
    logic [DATA_W-1:0]   vec_hi;
    logic [DATA_W-1:0]   vec_lo;

`ifdef INTR_PUSH_FLAGS_EN
    logic [FLAGS_W-1:0]  saved_flags;
`else
    logic                unused_flags;
    assign unused_flags = ^flags_in;
`endif

    // A new sequence begins from IDLE on a fresh pulse or a queued one.
    assign start = (state == IDLE) && (intr_in || pending);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Pending flag: one-deep queue for pulses arriving mid-sequence.
    always_ff @(posedge clk) begin
        if (rst)                        pending <= 1'b0;
        else if (start)                 pending <= 1'b0;
        else if (state != IDLE && intr_in) pending <= 1'b1;
    end

    // Capture return context at sequence start.
    always_ff @(posedge clk) begin
        if (rst) begin
            saved_pc <= '0;
`ifdef INTR_PUSH_FLAGS_EN
            saved_flags <= '0;
`endif
        end else if (start) begin
            saved_pc <= pc_in;
`ifdef INTR_PUSH_FLAGS_EN
            saved_flags <= flags_in;
`endif
        end
    end

    // Latch vector words as their reads complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_hi <= '0;
            vec_lo <= '0;
        end else begin
            if (state == RD_HI && mem_ack) vec_hi <= mem_rdata;
            if (state == RD_LO && mem_ack) vec_lo <= mem_rdata;
        end
    end

    // Next-state logic; memory states advance only on ack.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (intr_in || pending) state_next = FLUSH;
            FLUSH:    state_next = PUSH_HI;
            PUSH_HI:  if (mem_ack) state_next = PUSH_LO;
`ifdef INTR_PUSH_FLAGS_EN
            PUSH_LO:  if (mem_ack) state_next = PUSH_FLG;
            PUSH_FLG: if (mem_ack) state_next = RD_HI;
`else
            PUSH_LO:  if (mem_ack) state_next = RD_HI;
`endif
            RD_HI:    if (mem_ack) state_next = RD_LO;
            RD_LO:    if (mem_ack) state_next = LOAD;
            LOAD:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Moore output decode from state and held registers.
    always_comb begin
        busy        = (state != IDLE);
        stall_fetch = (state != IDLE);
        flush       = 1'b0;
        mem_push    = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        unique case (state)
            FLUSH: flush = 1'b1;
            PUSH_HI: begin
                mem_push  = 1'b1;
                mem_wdata = saved_pc[2*DATA_W-1:DATA_W];
            end
            PUSH_LO: begin
                mem_push  = 1'b1;
                mem_wdata = saved_pc[DATA_W-1:0];
            end
`ifdef INTR_PUSH_FLAGS_EN
            PUSH_FLG: begin
                mem_push  = 1'b1;
                mem_wdata = DATA_W'(saved_flags);
            end
`endif
            RD_HI: begin
                mem_rd   = 1'b1;
                mem_addr = VEC_HI_A;
            end
            RD_LO: begin
                mem_rd   = 1'b1;
                mem_addr = VEC_LO_A;
            end
            LOAD: begin
                pc_load     = 1'b1;
                pc_load_val = {vec_hi, vec_lo};
            end
            default: ;
        endcase
    end

endmodule
